sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO; next generation of the fixed 16x12 dual-clock FIFO wrapper. Generalised in width, depth (non-power-of-two allowed) and read mode (normal/show-ahead). Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous clear. Used for same-clock-domain buffering between FPGA datapath stages.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/sync_fifo_param_if.sv | 39 +++
 rtl/fifo_ram_sdp.sv | 34 +++
 rtl/sync_fifo_param.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for sync_fifo_param: address-width math and elaboration-time
// parameter legality checks used by the FIFO top level.
package fifo_pkg;

    function automatic int fifo_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // usedw must represent 0..DEPTH inclusive, hence one bit beyond the address
    function automatic int usedw_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    localparam int DEFAULT_ADDR_BITS = 4;
    localparam int DEFAULT_USEDW_W   = DEFAULT_ADDR_BITS + 1;

endpackage

`define FIFO_CHECK_DEPTH(D, A) \
    if ((D) < 2 || fifo_pkg::fifo_clog2(D) > (A)) begin : g_bad_depth \
        $error("sync_fifo_param: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_BITS"); \
    end

`define FIFO_CHECK_THRESH(AF, AE, D) \
    if ((AF) > (D) || (AE) > (D) || (AF) < 0 || (AE) < 0) begin : g_bad_thresh \
        $error("sync_fifo_param: thresholds must lie in 0..DEPTH"); \
    end

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a FIFO user (master) and sync_fifo_param (slave).
// The hwm member exists only when FIFO_HWM_EN is defined.
interface sync_fifo_param_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 4
);
    logic [WIDTH-1:0]   data;
    logic               wrreq;
    logic               rdreq;
    logic               sclr;
    logic               full;
    logic               almost_full;
    logic               empty;
    logic               almost_empty;
    logic               overflow;
    logic               underflow;
    logic [WIDTH-1:0]   q;
    logic [ADDR_BITS:0] usedw;
`ifdef FIFO_HWM_EN
    logic [ADDR_BITS:0] hwm;
`endif

    modport master (
        output data, wrreq, rdreq, sclr,
        input  full, almost_full, empty, almost_empty, overflow, underflow, q, usedw
`ifdef FIFO_HWM_EN
        , input hwm
`endif
    );

    modport slave (
        input  data, wrreq, rdreq, sclr,
        output full, almost_full, empty, almost_empty, overflow, underflow, q, usedw
`ifdef FIFO_HWM_EN
        , output hwm
`endif
    );

endinterface

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port whose output
// register resets to zero (the array itself is never reset).
module fifo_ram_sdp #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 12,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with normal/show-ahead read, threshold flags,
// sticky overflow/underflow and synchronous clear. FIFO_HWM_EN adds the hwm output.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 12,
    parameter int ADDR_BITS     = 4,
    parameter int AFULL_THRESH  = 10,
    parameter int AEMPTY_THRESH = 2,
    parameter int SHOWAHEAD     = 0
) (
    input logic              clk,
    input logic              aclr_n,
    sync_fifo_param_if.slave bus
);

    `FIFO_CHECK_DEPTH(DEPTH, ADDR_BITS)
    `FIFO_CHECK_THRESH(AFULL_THRESH, AEMPTY_THRESH, DEPTH)

    localparam int UW = usedw_width(ADDR_BITS);

    typedef logic [ADDR_BITS-1:0] ptr_t;
    typedef logic [UW-1:0]        cnt_t;

    // Depth need not be a power of two, so wrap is an explicit compare
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    ptr_t             wr_ptr, rd_ptr;
    cnt_t             cnt, cnt_next;
    logic             full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;
    logic             head_valid, head_next;
    logic             wr_ok, rd_ok, fetch, empty_next;
    logic [WIDTH-1:0] q_word;

    // In show-ahead mode the head word lives in the RAM output register, so the
    // FIFO only looks non-empty once a prefetch has actually landed there.
    always_comb begin
        wr_ok    = bus.wrreq && !full_r;
        rd_ok    = bus.rdreq && !empty_r;
        cnt_next = cnt;
        if (wr_ok && !rd_ok) begin
            cnt_next = cnt + cnt_t'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt_next = cnt - cnt_t'(1);
        end
        fetch     = rd_ok;
        head_next = 1'b0;
        if (SHOWAHEAD != 0) begin
            fetch     = (cnt != cnt_t'(head_valid)) && (!head_valid || rd_ok);
            head_next = fetch || (head_valid && !rd_ok);
        end
        empty_next = (SHOWAHEAD != 0) ? !head_next : (cnt_next == '0);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            head_valid <= 1'b0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            afull_r    <= (AFULL_THRESH == 0);
            aempty_r   <= 1'b1;
            ovf_r      <= 1'b0;
            udf_r      <= 1'b0;
        end else if (bus.sclr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            head_valid <= 1'b0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            afull_r    <= (AFULL_THRESH == 0);
            aempty_r   <= 1'b1;
            ovf_r      <= 1'b0;
            udf_r      <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (fetch) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt        <= cnt_next;
            head_valid <= head_next;
            full_r     <= (cnt_next == cnt_t'(DEPTH));
            empty_r    <= empty_next;
            afull_r    <= (cnt_next >= cnt_t'(AFULL_THRESH));
            aempty_r   <= (cnt_next <= cnt_t'(AEMPTY_THRESH));
            if (bus.wrreq && full_r) begin
                ovf_r <= 1'b1;
            end
            if (bus.rdreq && empty_r) begin
                udf_r <= 1'b1;
            end
        end
    end

    // Write gated by reset so nothing lands in RAM while aclr_n is asserted
    fifo_ram_sdp #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .rst_n   (aclr_n),
        .wr_en   (wr_ok && !bus.sclr && aclr_n),
        .wr_addr (wr_ptr),
        .wr_data (bus.data),
        .rd_en   (fetch && !bus.sclr),
        .rd_addr (rd_ptr),
        .rd_data (q_word)
    );

`ifdef FIFO_HWM_EN
    cnt_t hwm_r;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            hwm_r <= '0;
        end else if (bus.sclr) begin
            hwm_r <= '0;
        end else if (cnt_next > hwm_r) begin
            hwm_r <= cnt_next;
        end
    end

    assign bus.hwm = hwm_r;
`endif

    assign bus.q            = q_word;
    assign bus.usedw        = cnt;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = afull_r;
    assign bus.almost_empty = aempty_r;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a normal-mode instance checked every
// cycle against a queue model, plus a show-ahead instance with directed checks.
module tb_sync_fifo_param;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 12;
    localparam int ADDR_BITS = 4;
    localparam int AF        = 10;
    localparam int AE        = 2;

    logic clk;
    logic aclr_n;

    int n_checks = 0;
    int n_fails  = 0;

    int          m_cnt;
    logic [15:0] sb [$];
    logic [15:0] m_q;
    bit          m_ovf;
    bit          m_udf;
    int          m_hwm;

    sync_fifo_param_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();
    sync_fifo_param_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus_sa ();

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .SHOWAHEAD(0)
    ) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .SHOWAHEAD(1)
    ) dut_sa (
        .clk    (clk),
        .aclr_n (aclr_n),
        .bus    (bus_sa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_cnt = 0;
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_hwm = 0;
    endtask

    task automatic checkState();
        checkOutput("usedw", 32'(bus.usedw), 32'(m_cnt));
        checkOutput("full", 32'(bus.full), 32'(m_cnt == DEPTH));
        checkOutput("empty", 32'(bus.empty), 32'(m_cnt == 0));
        checkOutput("almost_full", 32'(bus.almost_full), 32'(m_cnt >= AF));
        checkOutput("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= AE));
        checkOutput("overflow", 32'(bus.overflow), 32'(m_ovf));
        checkOutput("underflow", 32'(bus.underflow), 32'(m_udf));
        checkOutput("q", 32'(bus.q), 32'(m_q));
`ifdef FIFO_HWM_EN
        checkOutput("hwm", 32'(bus.hwm), 32'(m_hwm));
`endif
    endtask

    // Drives one cycle on the normal-mode instance (called just after a negedge),
    // updates the scoreboard, then checks all outputs at the next negedge.
    task automatic applyStimulus(input bit wr, input bit rd, input bit sc, input logic [15:0] d);
        bit wok;
        bit rok;
        bus.wrreq = wr;
        bus.rdreq = rd;
        bus.sclr  = sc;
        bus.data  = d;
        wok = wr && (m_cnt != DEPTH) && !sc;
        rok = rd && (m_cnt != 0) && !sc;
        if (sc) begin
            modelReset();
        end else begin
            if (wr && m_cnt == DEPTH) m_ovf = 1'b1;
            if (rd && m_cnt == 0) m_udf = 1'b1;
            if (rok) m_q = sb.pop_front();
            if (wok) sb.push_back(d);
            m_cnt = m_cnt + int'(wok) - int'(rok);
            if (m_cnt > m_hwm) m_hwm = m_cnt;
        end
        @(posedge clk);
        @(negedge clk);
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        bus.sclr  = 1'b0;
        checkState();
    endtask

    initial begin
        logic [15:0] sa_vals [3];
        sa_vals[0] = 16'h00B1;
        sa_vals[1] = 16'h00B2;
        sa_vals[2] = 16'h00B3;

        // Reset held three cycles with a write pending
        aclr_n       = 1'b0;
        bus.wrreq    = 1'b1;
        bus.rdreq    = 1'b0;
        bus.sclr     = 1'b0;
        bus.data     = 16'h1234;
        bus_sa.wrreq = 1'b1;
        bus_sa.rdreq = 1'b0;
        bus_sa.sclr  = 1'b0;
        bus_sa.data  = 16'h4321;
        modelReset();
        m_q = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkState();
        checkOutput("sa_reset_empty", 32'(bus_sa.empty), 32'd1);
        checkOutput("sa_reset_q", 32'(bus_sa.q), 32'd0);
        bus.wrreq    = 1'b0;
        bus_sa.wrreq = 1'b0;
        aclr_n       = 1'b1;
        @(negedge clk);
        checkState();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

        // Fill to full, then one rejected write
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(i));
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hDEAD);

        // Drain everything, then clear the sticky overflow
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);

        // Steady-state simultaneous access across pointer wrap
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'(16'h0200 + i));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0300);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);

        // Random traffic with occasional clears
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0), 16'($urandom));
        end

        // High-water mark scenario
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(16'h0400 + i));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(16'h0500 + i));
`ifdef FIFO_HWM_EN
        checkOutput("hwm_peak", 32'(bus.hwm), 32'd7);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
`ifdef FIFO_HWM_EN
        checkOutput("hwm_cleared", 32'(bus.hwm), 32'd0);
`endif

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(16'h0600 + i));
        bus.wrreq = 1'b1;
        bus.data  = 16'h0777;
        @(posedge clk);
        #2 aclr_n = 1'b0;
        #1;
        modelReset();
        m_q = 16'h0000;
        checkOutput("midreset_usedw", 32'(bus.usedw), 32'd0);
        checkOutput("midreset_empty", 32'(bus.empty), 32'd1);
        checkOutput("midreset_q", 32'(bus.q), 32'd0);
        @(negedge clk);
        bus.wrreq = 1'b0;
        aclr_n    = 1'b1;
        @(negedge clk);
        checkState();

        // Show-ahead: head prefetch latency and pop
        bus_sa.wrreq = 1'b1;
        bus_sa.data  = 16'h00A5;
        @(posedge clk);
        @(negedge clk);
        bus_sa.wrreq = 1'b0;
        checkOutput("sa_empty_edge1", 32'(bus_sa.empty), 32'd1);
        checkOutput("sa_usedw_edge1", 32'(bus_sa.usedw), 32'd1);
        @(negedge clk);
        checkOutput("sa_q_edge2", 32'(bus_sa.q), 32'h00A5);
        checkOutput("sa_empty_edge2", 32'(bus_sa.empty), 32'd0);
        bus_sa.rdreq = 1'b1;
        @(negedge clk);
        bus_sa.rdreq = 1'b0;
        checkOutput("sa_empty_pop", 32'(bus_sa.empty), 32'd1);
        checkOutput("sa_usedw_pop", 32'(bus_sa.usedw), 32'd0);
        checkOutput("sa_underflow", 32'(bus_sa.underflow), 32'd0);

        // Show-ahead: back-to-back writes then consecutive pops
        for (int i = 0; i < 3; i++) begin
            bus_sa.wrreq = 1'b1;
            bus_sa.data  = sa_vals[i];
            @(negedge clk);
        end
        bus_sa.wrreq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("sa_head", 32'(bus_sa.q), 32'(sa_vals[i]));
            checkOutput("sa_not_empty", 32'(bus_sa.empty), 32'd0);
            bus_sa.rdreq = 1'b1;
            @(negedge clk);
        end
        bus_sa.rdreq = 1'b0;
        checkOutput("sa_drained_empty", 32'(bus_sa.empty), 32'd1);
        checkOutput("sa_drained_usedw", 32'(bus_sa.usedw), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
